// File: rtl/fetch_decode.sv
// RV32I fetch and pre-decode stage: owns the fetch PC, issues word requests to
// instruction memory and buffers one decoded instruction for downstream stages.
module fetch_decode #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic [5:0]  I_fmt,
  output logic [2:0]  funct3,
  output logic        illegal
);

  localparam logic [5:0] FMT_R = 6'b100000;
  localparam logic [5:0] FMT_I = 6'b010000;
  localparam logic [5:0] FMT_S = 6'b001000;
  localparam logic [5:0] FMT_B = 6'b000100;
  localparam logic [5:0] FMT_U = 6'b000010;
  localparam logic [5:0] FMT_J = 6'b000001;
  localparam logic [5:0] FMT_X = 6'b000000;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DISCARD = 2'd2,
    FULL    = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] fetch_pc_reg, fetch_pc_next;
  logic        out_valid_next;
  logic        capture;
  logic        req_next;
  logic [31:0] addr_next;
  logic [5:0]  fmt_dec;

  // Opcode-only decode; the low two bits must be 11 for a 32-bit RV32I word.
  function automatic logic [5:0] decode_fmt(input logic [6:0] opcode);
    logic [5:0] f;
    f = FMT_X;
    if (opcode[1:0] == 2'b11) begin
      case (opcode)
        7'b0110011: f = FMT_R;
        7'b0010011,
        7'b0000011,
        7'b1100111,
        7'b0001111,
        7'b1110011: f = FMT_I;
        7'b0100011: f = FMT_S;
        7'b1100011: f = FMT_B;
        7'b0110111,
        7'b0010111: f = FMT_U;
        7'b1101111: f = FMT_J;
        default:    f = FMT_X;
      endcase
    end
    return f;
  endfunction

  assign fmt_dec = decode_fmt(imem_rdata[6:0]);

  always_comb begin
    state_next     = state_reg;
    fetch_pc_next  = fetch_pc_reg;
    out_valid_next = out_valid;
    capture        = 1'b0;

    case (state_reg)
      IDLE: state_next = FETCH;
      FETCH: begin
        if (imem_ready) begin
          capture        = 1'b1;
          out_valid_next = 1'b1;
          state_next     = FULL;
        end
      end
      FULL: begin
        if (out_ready) begin
          out_valid_next = 1'b0;
          fetch_pc_next  = pc + 32'd4;
          state_next     = FETCH;
        end
      end
      DISCARD: begin
        if (imem_ready) state_next = FETCH;
      end
      default: state_next = IDLE;
    endcase

    // A redirect overrides everything; an outstanding request is always
    // allowed to complete (via DISCARD) before the new target is fetched.
    if (redirect_valid) begin
      fetch_pc_next  = redirect_pc & ~32'h3;
      capture        = 1'b0;
      out_valid_next = 1'b0;
      case (state_reg)
        FETCH, DISCARD: state_next = imem_ready ? FETCH : DISCARD;
        default:        state_next = FETCH;
      endcase
    end

    req_next  = (state_next == FETCH) || (state_next == DISCARD);
    // DISCARD keeps presenting the old address until its response returns.
    addr_next = (state_next == FETCH) ? fetch_pc_next : imem_addr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      fetch_pc_reg <= RESET_PC;
      imem_req     <= 1'b0;
      imem_addr    <= RESET_PC;
      out_valid    <= 1'b0;
      inst         <= NOP;
      pc           <= RESET_PC;
      I_fmt        <= FMT_I;
      funct3       <= 3'b000;
      illegal      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      imem_req     <= req_next;
      imem_addr    <= addr_next;
      out_valid    <= out_valid_next;
      if (capture) begin
        inst    <= imem_rdata;
        pc      <= fetch_pc_reg;
        I_fmt   <= fmt_dec;
        funct3  <= imem_rdata[14:12];
        illegal <= (fmt_dec == FMT_X);
      end
    end
  end

endmodule
